// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - snapshot the MAC array results, convert to FP16, stream out in PE order
module systolic_drain #(
   parameter int ACC_WIDTH = 32,
   parameter int N         = 2,
   parameter int FRAC_BITS = 10,
   parameter int IDX_W     = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       done,
   input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
   input  logic [N*N*5-1:0]           exp_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_data,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
   output logic                       busy,
   output logic                       missed
);

   localparam int NN = N * N;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

   state_t                 state, state_nx;
   logic                   done_q;
   logic                   trigger;
   logic [IDX_W-1:0]       idx;
   logic [ACC_WIDTH-1:0]   acc_snap [NN];
   logic [4:0]             exp_snap [NN];

   // Signed fixed-point accumulator scaled by 2^(ex-15-FRAC_BITS) to FP16, truncating, no subnormals
   function automatic logic [15:0] to_fp16(input logic [ACC_WIDTH-1:0] acc, input logic [4:0] ex);
      logic                 s;
      logic [ACC_WIDTH-1:0] mag;
      logic [9:0]           m;
      int                   p;
      int                   e;
      s   = acc[ACC_WIDTH-1];
      mag = s ? -acc : acc;
      p   = 0;
      for (int i = 0; i < ACC_WIDTH; i++) begin
         if (mag[i]) p = i;
      end
      e = p + int'(ex) - FRAC_BITS;
      m = 10'({mag, 10'b0} >> p);
      if (mag == '0)      to_fp16 = 16'h0000;
      else if (e >= 31)   to_fp16 = {s, 5'h1F, 10'h000};
      else if (e <= 0)    to_fp16 = {s, 15'h0000};
      else                to_fp16 = {s, e[4:0], m};
   endfunction

   assign trigger   = done & ~done_q;
   assign out_valid = (state == SEND);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (trigger) state_nx = CONV;
         CONV:    state_nx = SEND;
         SEND:    if (out_ready) state_nx = (idx == LAST_IDX) ? IDLE : CONV;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q   <= 1'b0;
         missed   <= 1'b0;
         idx      <= '0;
         out_data <= 16'h0000;
         out_idx  <= '0;
         out_last <= 1'b0;
         for (int i = 0; i < NN; i++) begin
            acc_snap[i] <= '0;
            exp_snap[i] <= '0;
         end
      end else begin
         done_q <= done;
         // Edges arriving mid-drain are reported, never acted on
         missed <= trigger && (state != IDLE);
         case (state)
            IDLE: begin
               if (trigger) begin
                  idx <= '0;
                  for (int i = 0; i < NN; i++) begin
                     acc_snap[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
                     exp_snap[i] <= exp_in[i*5 +: 5];
                  end
               end
            end
            CONV: begin
               out_data <= to_fp16(acc_snap[idx], exp_snap[idx]);
               out_idx  <= idx;
               out_last <= (idx == LAST_IDX);
            end
            SEND: begin
               if (out_ready) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - randomized and directed checks of systolic_drain against an arithmetic FP16 model
module tb_systolic_drain;

   localparam int AW = 32;
   localparam int N  = 2;
   localparam int NN = N * N;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              done;
   logic [NN*AW-1:0]  acc_in;
   logic [NN*5-1:0]   exp_in;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic [IW-1:0]     out_idx;
   logic              out_last;
   logic              busy;
   logic              missed;

   int                checks = 0;
   int                errors = 0;
   logic [31:0]       acc_v [NN];
   logic [4:0]        ex_v  [NN];
   logic [15:0]       want  [NN];

   always #5 clk = ~clk;

   systolic_drain #(.ACC_WIDTH(AW), .N(N), .FRAC_BITS(10), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .done(done), .acc_in(acc_in), .exp_in(exp_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy), .missed(missed)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // value = acc * 2^(ex-25); FP16 fields derived from floor(log2|acc|)
   function automatic logic [15:0] ref_fp16(input logic [31:0] acc, input logic [4:0] ex);
      longint a, mag;
      int     p, e;
      logic   s;
      a   = longint'($signed(acc));
      s   = (a < 0);
      mag = s ? -a : a;
      if (mag == 0) return 16'h0000;
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      e = p + int'(ex) - 10;
      if (e >= 31) return {s, 5'h1F, 10'h000};
      if (e <= 0)  return {s, 15'h0000};
      return {s, 5'(e), 10'(((mag * 1024) / (longint'(1) << p)) % 1024)};
   endfunction

   task automatic apply();
      for (int i = 0; i < NN; i++) begin
         acc_in[i*AW +: AW] = acc_v[i];
         exp_in[i*5 +: 5]   = ex_v[i];
         want[i]            = ref_fp16(acc_v[i], ex_v[i]);
      end
   endtask

   task automatic randomize_data();
      for (int i = 0; i < NN; i++) begin
         acc_v[i] = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) acc_v[i] = -acc_v[i];
         if ($urandom_range(0, 9) == 0) acc_v[i] = 32'h0;
         ex_v[i] = 5'($urandom_range(0, 31));
      end
      apply();
   endtask

   task automatic fire();
      @(negedge clk) done = 1'b0;
      @(negedge clk) done = 1'b1;
   endtask

   // mode 0: ready high, 1: random ready, 2: 5-cycle stall per element, 3: ready high + done re-edge mid-drain
   task automatic drain(input int mode);
      int          got = 0;
      int          k = 0;
      int          stall = 0;
      bit          prev_hold = 0;
      bit          seen = 0;
      logic [15:0] hd = '0;
      logic [IW-1:0] hi = '0;
      while (got < NN && k < 300) begin
         @(negedge clk);
         k++;
         check("missed", missed, (mode == 3 && k == 5));
         if (k == 1) begin
            check("latency_conv_valid", out_valid, 0);
            check("latency_conv_busy", busy, 1);
            acc_in = {$urandom, $urandom, $urandom, $urandom};
            exp_in = 20'($urandom);
         end
         if (k == 2) check("latency_send_valid", out_valid, 1);
         if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hd);
            check("hold_idx", out_idx, hi);
         end
         if (out_valid && !seen) begin
            check($sformatf("data_idx%0d", got), out_data, want[got]);
            check("idx", out_idx, got);
            check("last", out_last, (got == NN - 1));
            seen = 1;
         end
         case (mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (out_valid && stall < 5) begin
                  out_ready = 1'b0;
                  stall++;
               end else out_ready = 1'b1;
            end
            default: out_ready = 1'b1;
         endcase
         if (mode == 3 && k == 3) done = 1'b0;
         if (mode == 3 && k == 4) done = 1'b1;
         prev_hold = out_valid && !out_ready;
         hd = out_data;
         hi = out_idx;
         if (out_valid && out_ready) begin
            got++;
            seen  = 0;
            stall = 0;
         end
      end
      check("drain_complete", got, NN);
      @(negedge clk);
      check("busy_after", busy, 0);
      check("valid_after", out_valid, 0);
   endtask

   initial begin
      rst = 1'b0; done = 1'b0; out_ready = 1'b0; acc_in = '0; exp_in = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      check("rst_idx", out_idx, 0);
      check("rst_last", out_last, 0);
      check("rst_missed", missed, 0);
      rst = 1'b1;

      acc_v = '{32'h00000400, 32'hFFFF9000, 32'hFFFFAC00, 32'h00000000};
      ex_v  = '{5'd15, 5'd15, 5'd15, 5'd15};
      apply();
      want  = '{16'h3C00, 16'hCF00, 16'hCD40, 16'h0000};
      fire();
      drain(0);

      randomize_data();
      fire();
      drain(2);

      acc_v = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'hFFFFFC00};
      ex_v  = '{5'd15, 5'd0, 5'd0, 5'd15};
      apply();
      want  = '{16'h7C00, 16'h0000, 16'hD400, 16'hBC00};
      fire();
      drain(1);

      randomize_data();
      fire();
      drain(3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_retrigger", busy, 0);
      end

      begin
         int w = 0;
         randomize_data();
         out_ready = 1'b1;
         fire();
         while (!(out_valid && out_idx == 1) && w < 40) begin
            @(negedge clk);
            w++;
         end
         check("reach_idx1", (out_valid && out_idx == 1), 1);
         out_ready = 1'b0;
         #1 rst = 1'b0;
         #1;
         check("async_rst_valid", out_valid, 0);
         check("async_rst_busy", busy, 0);
         check("async_rst_idx", out_idx, 0);
         done = 1'b0;
         @(negedge clk) rst = 1'b1;
         @(negedge clk);
         check("post_rst_idle", busy, 0);
      end
      randomize_data();
      fire();
      drain(0);

      for (int r = 0; r < 15; r++) begin
         randomize_data();
         fire();
         drain(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
